// File: rtl/switch_debouncer.sv
// Two/three-flop synchroniser plus per-bit stability counter for slide switches; no backpressure.
// Latency DEBOUNCE_CYCLES+2 edges, or DEBOUNCE_CYCLES+3 with SWITCH_SYNC3_EN defined (3-flop synchroniser).
module switch_debouncer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] switches_raw,
    output logic [WIDTH-1:0] switches,
    output logic [WIDTH-1:0] sw_changed,
    output logic             any_changed
);

`ifdef SWITCH_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]                  stable_q, stable_d;
    logic [WIDTH-1:0]                  sw_changed_q, sw_changed_d;
    logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]                  sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], switches_raw};
        stable_d     = stable_q;
        cnt_d        = cnt_q;
        sw_changed_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                // Acceptance fires before the counter could wrap.
                stable_d[i]     = sync[i];
                cnt_d[i]        = '0;
                sw_changed_d[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q       <= '0;
            stable_q     <= '0;
            cnt_q        <= '0;
            sw_changed_q <= '0;
        end else begin
            sync_q       <= sync_d;
            stable_q     <= stable_d;
            cnt_q        <= cnt_d;
            sw_changed_q <= sw_changed_d;
        end
    end

    assign switches    = stable_q;
    assign sw_changed  = sw_changed_q;
    assign any_changed = |sw_changed_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with DEBOUNCE_CYCLES=4, WIDTH=8.
module tb_switch_debouncer;

    logic       clk;
    logic       rst;
    logic [7:0] switches_raw;
    logic [7:0] switches;
    logic [7:0] sw_changed;
    logic       any_changed;

    int n_checks;
    int n_fail;

    switch_debouncer #(
        .WIDTH          (8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .switches_raw(switches_raw),
        .switches    (switches),
        .sw_changed  (sw_changed),
        .any_changed (any_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        switches_raw = 8'hFF;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            n_checks++;
            if ({switches, sw_changed, any_changed} !== {8'h00, 8'h00, 1'b0}) begin
                n_fail++;
                $display("FAIL reset j=%0d: sw=%h chg=%h any=%b, want sw=00 chg=00 any=0",
                         j, switches, sw_changed, any_changed);
            end
        end
        switches_raw = 8'h00;
        rst          = 1'b0;
        idle(3);
    endtask

    task automatic test_single_change();
        logic [7:0] exp_sw, exp_chg;
        switches_raw = 8'h01;  // next posedge is edge k
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);    // after edge k+j
            exp_sw  = (j >= 5) ? 8'h01 : 8'h00;
            exp_chg = (j == 5) ? 8'h01 : 8'h00;
            n_checks++;
            if ({switches, sw_changed, any_changed} !== {exp_sw, exp_chg, (j == 5)}) begin
                n_fail++;
                $display("FAIL single j=%0d: sw=%h chg=%h any=%b, want sw=%h chg=%h any=%b",
                         j, switches, sw_changed, any_changed, exp_sw, exp_chg, (j == 5));
            end
        end
    endtask

    task automatic test_bounce();
        int lv [4];
        int hd [4];
        lv = '{1, 0, 1, 0};
        hd = '{2, 1, 3, 2};
        for (int p = 0; p < 4; p++) begin
            for (int h = 0; h < hd[p]; h++) begin
                switches_raw[3] = lv[p][0];
                @(negedge clk);
                n_checks++;
                if ({switches, sw_changed, any_changed} !== {8'h01, 8'h00, 1'b0}) begin
                    n_fail++;
                    $display("FAIL bounce p=%0d h=%0d: sw=%h chg=%h any=%b, want sw=01 chg=00 any=0",
                             p, h, switches, sw_changed, any_changed);
                end
            end
        end
        switches_raw[3] = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            n_checks++;
            if ({switches, sw_changed, any_changed} !== {8'h01, 8'h00, 1'b0}) begin
                n_fail++;
                $display("FAIL bounce_hold j=%0d: sw=%h chg=%h any=%b, want sw=01 chg=00 any=0",
                         j, switches, sw_changed, any_changed);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_sw, exp_chg;
        switches_raw = 8'h00;
        idle(10);
        n_checks++;
        if (switches !== 8'h00) begin
            n_fail++;
            $display("FAIL simul_base: sw=%h, want 00", switches);
        end
        switches_raw = 8'hA5;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            exp_sw  = (j >= 5) ? 8'hA5 : 8'h00;
            exp_chg = (j == 5) ? 8'hA5 : 8'h00;
            n_checks++;
            if ({switches, sw_changed, any_changed} !== {exp_sw, exp_chg, (j == 5)}) begin
                n_fail++;
                $display("FAIL simul j=%0d: sw=%h chg=%h any=%b, want sw=%h chg=%h any=%b",
                         j, switches, sw_changed, any_changed, exp_sw, exp_chg, (j == 5));
            end
        end
    endtask

    task automatic test_release_path();
        logic [7:0] exp_sw, exp_chg;
        switches_raw = 8'hFF;
        idle(10);
        n_checks++;
        if (switches !== 8'hFF) begin
            n_fail++;
            $display("FAIL release_base: sw=%h, want ff", switches);
        end
        switches_raw = 8'h7F;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            exp_sw  = (j >= 5) ? 8'h7F : 8'hFF;
            exp_chg = (j == 5) ? 8'h80 : 8'h00;
            n_checks++;
            if ({switches, sw_changed, any_changed} !== {exp_sw, exp_chg, (j == 5)}) begin
                n_fail++;
                $display("FAIL release j=%0d: sw=%h chg=%h any=%b, want sw=%h chg=%h any=%b",
                         j, switches, sw_changed, any_changed, exp_sw, exp_chg, (j == 5));
            end
        end
    endtask

    task automatic test_reset_mid_count();
        logic [7:0] exp_sw, exp_chg;
        switches_raw = 8'h00;
        idle(10);
        switches_raw = 8'h02;  // next posedge is edge k
        idle(3);               // after edges k, k+1, k+2
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_checks++;
            if ({switches, sw_changed, any_changed} !== {8'h00, 8'h00, 1'b0}) begin
                n_fail++;
                $display("FAIL midrst_hold j=%0d: sw=%h chg=%h any=%b, want sw=00 chg=00 any=0",
                         j, switches, sw_changed, any_changed);
            end
        end
        rst = 1'b0;  // next posedge is the first post-reset edge
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            exp_sw  = (j >= 5) ? 8'h02 : 8'h00;
            exp_chg = (j == 5) ? 8'h02 : 8'h00;
            n_checks++;
            if ({switches, sw_changed, any_changed} !== {exp_sw, exp_chg, (j == 5)}) begin
                n_fail++;
                $display("FAIL midrst j=%0d: sw=%h chg=%h any=%b, want sw=%h chg=%h any=%b",
                         j, switches, sw_changed, any_changed, exp_sw, exp_chg, (j == 5));
            end
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        switches_raw = 8'h00;
        test_reset();
        test_single_change();
        test_bounce();
        test_simultaneous();
        test_release_path();
        test_reset_mid_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
